// File: rtl/iob_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : iob_mem_resp
// Purpose  : IOb-native bus responder backed by a byte-writable word memory.
//            Programmable wait states ahead of accept, programmable read
//            latency, one rvalid pulse per accepted read, and a sticky error
//            flag for accesses outside the memory range.
// Ports    : clk_i, arst_n_i (async, active-low), cke_i (freezes all state)
//            avalid_i/addr_i/wdata_i/wstrb_i  request (wstrb_i==0 -> read)
//            ready_o                          request accepted this cycle
//            rdata_o/rvalid_o                 read response
//            err_o/err_clr_i                  sticky out-of-range flag
// Revision : 1.0  initial release
// ============================================================================
module iob_mem_resp #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 0,
  parameter int READ_LAT    = 1
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                avalid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                ready_o,
  output logic                err_o,
  input  logic                err_clr_i
);

  localparam int         c_strb_w    = DATA_W / 8;
  localparam int         c_depth     = 1 << MEM_ADDR_W;
  localparam logic [3:0] c_wait_last = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [2:0] c_read_lat  = 3'(READ_LAT);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACC  = 2'd2,
    ST_READ = 2'd3
  } state_t;

  // State the responder falls back to after any completed or withdrawn
  // transaction: with no wait states it simply stays ready.
  localparam state_t c_home = (WAIT_STATES == 0) ? ST_ACC : ST_IDLE;

  state_t                  state_q, state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [2:0]              lat_cnt_q, lat_cnt_d;
  logic [MEM_ADDR_W-1:0]   idx_q, idx_d;
  logic                    oor_q, oor_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_W-1:0]       mem [c_depth];

  logic                    w_oor;
  logic [MEM_ADDR_W-1:0]   w_idx;
  logic                    w_acc;
  logic                    w_wr_acc;
  logic [MEM_ADDR_W-1:0]   w_rd_idx;
  logic                    w_rd_oor;
  logic                    w_load;
  logic                    w_unused_addr_lsb;

  // Byte offset within the word is irrelevant: strobes select the lanes.
  assign w_unused_addr_lsb = ^addr_i[1:0];
  assign w_idx             = addr_i[MEM_ADDR_W+1:2];

  generate
    if (ADDR_W > MEM_ADDR_W + 2) begin : g_oor
      assign w_oor = |addr_i[ADDR_W-1:MEM_ADDR_W+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_acc    = (state_q == ST_ACC) && avalid_i;
  assign w_wr_acc = w_acc && (|wstrb_i);

  // Out-of-range writes are dropped; in-range writes update only the
  // strobed byte lanes.
  always_ff @(posedge clk_i) begin
    if (cke_i && w_wr_acc && !w_oor) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (wstrb_i[b]) begin
          mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    w_rd_idx   = idx_q;
    w_rd_oor   = oor_q;
    w_load     = 1'b0;

    // A new error outranks a simultaneous clear.
    if (err_clr_i) err_d = 1'b0;
    if (w_acc && w_oor) err_d = 1'b1;

    unique case (state_q)
      ST_RST: begin
        state_d = c_home;
      end
      ST_IDLE: begin
        // Once started, the wait count runs to completion.
        if (avalid_i || (wait_cnt_q != 4'd0)) begin
          if (wait_cnt_q == c_wait_last) begin
            state_d    = ST_ACC;
            wait_cnt_d = 4'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end
      ST_ACC: begin
        if (!avalid_i || (|wstrb_i)) begin
          state_d = c_home;
        end else begin
          state_d   = ST_READ;
          idx_d     = w_idx;
          oor_d     = w_oor;
          lat_cnt_d = 3'd1;
          // Single-cycle latency: the response is launched on the accept edge.
          if (c_read_lat == 3'd1) begin
            w_load   = 1'b1;
            w_rd_idx = w_idx;
            w_rd_oor = w_oor;
          end
        end
      end
      ST_READ: begin
        // lat_cnt_q counts cycles since accept; the response occupies the
        // last READ cycle, then the responder returns to home.
        if (lat_cnt_q == c_read_lat) begin
          state_d   = c_home;
          lat_cnt_d = 3'd0;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
          if ((lat_cnt_q + 3'd1) == c_read_lat) begin
            w_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    if (w_load) begin
      rvalid_d = 1'b1;
      rdata_d  = w_rd_oor ? '0 : mem[w_rd_idx];
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_RST;
      wait_cnt_q <= 4'd0;
      lat_cnt_q  <= 3'd0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      idx_q      <= idx_d;
      oor_q      <= oor_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign ready_o  = (state_q == ST_ACC);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire
